// File: rtl/load_kind_decoder_pkg.sv
// Shared instruction-type definitions: load kinds, LOAD funct3 encodings, access sizes.
package instr_type;

  typedef enum logic [2:0] {
    lk_lb      = 3'd0,
    lk_lh      = 3'd1,
    lk_lw      = 3'd2,
    lk_lbu     = 3'd3,
    lk_lhu     = 3'd4,
    lk_invalid = 3'd7
  } load_kind_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_NONE = 2'b11;

endpackage

// File: rtl/load_kind_decoder_if.sv
// Decode-stage bundle: funct3 in, registered load attributes out.
interface load_kind_decoder_if;

  logic [2:0]             funct3;
  instr_type::load_kind_t kind;
  logic [1:0]             size;
  logic                   zero_ext;
  logic                   illegal;

  modport master (output funct3, input kind, size, zero_ext, illegal);
  modport slave  (input funct3, output kind, size, zero_ext, illegal);

endinterface

// File: rtl/load_kind_decoder_funct3_comb.sv
// Pure combinational decode of a LOAD funct3 into kind and access attributes.
module load_funct3_comb
  import instr_type::*;
(
  input  logic [2:0] funct3,
  output load_kind_t kind,
  output logic [1:0] size,
  output logic       zero_ext,
  output logic       illegal
);

  // Table decode; anything unrecognised (including X/Z) falls to invalid.
  always_comb begin
    kind     = lk_invalid;
    size     = SZ_NONE;
    zero_ext = 1'b0;
    illegal  = 1'b1;
    case (funct3)
      F3_LB:  begin kind = lk_lb;  size = SZ_BYTE; illegal = 1'b0; end
      F3_LH:  begin kind = lk_lh;  size = SZ_HALF; illegal = 1'b0; end
      F3_LW:  begin kind = lk_lw;  size = SZ_WORD; illegal = 1'b0; end
      F3_LBU: begin kind = lk_lbu; size = SZ_BYTE; zero_ext = 1'b1; illegal = 1'b0; end
      F3_LHU: begin kind = lk_lhu; size = SZ_HALF; zero_ext = 1'b1; illegal = 1'b0; end
      default: begin
        kind     = lk_invalid;
        size     = SZ_NONE;
        zero_ext = 1'b0;
        illegal  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_kind_decoder.sv
// Registered LOAD funct3 decoder: one-cycle latency, synchronous active-low reset.
module load_kind_decoder
  import instr_type::*;
(
  input  logic                clk,
  input  logic                rst,
  load_kind_decoder_if.slave  bus
);

  load_kind_t kind_d, kind_q;
  logic [1:0] size_d, size_q;
  logic       zero_ext_d, zero_ext_q;
  logic       illegal_d, illegal_q;

  load_funct3_comb u_comb (
    .funct3   (bus.funct3),
    .kind     (kind_d),
    .size     (size_d),
    .zero_ext (zero_ext_d),
    .illegal  (illegal_d)
  );

  // Capture the decode every cycle; reset forces the invalid/illegal state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      kind_q     <= lk_invalid;
      size_q     <= SZ_NONE;
      zero_ext_q <= 1'b0;
      illegal_q  <= 1'b1;
    end else begin
      kind_q     <= kind_d;
      size_q     <= size_d;
      zero_ext_q <= zero_ext_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.kind     = kind_q;
  assign bus.size     = size_q;
  assign bus.zero_ext = zero_ext_q;
  assign bus.illegal  = illegal_q;

  // illegal and the invalid kind must always travel together.
  a_illegal_matches_kind: assert property (@(posedge clk) illegal_q == (kind_q == lk_invalid));

endmodule

// File: tb/tb_load_kind_decoder.sv
// Scoreboard bench for load_kind_decoder: driver pushes expectations, monitor checks.
module tb_load_kind_decoder;
  import instr_type::*;

  logic clk;
  logic rst;

  load_kind_decoder_if bus ();

  load_kind_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    load_kind_t kind;
    logic [1:0] size;
    logic       zx;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_vec;
  int unsigned n_bad;
  bit          done;

  // Drive one vector at the falling edge; its response is due after the next rising edge.
  task automatic apply(input string name, input logic r, input logic [2:0] f3,
                       input load_kind_t k, input logic [1:0] sz, input logic zx, input logic il);
    exp_t e;
    @(negedge clk);
    rst        = r;
    bus.funct3 = f3;
    e.name = name; e.kind = k; e.size = sz; e.zx = zx; e.ill = il;
    exp_q.push_back(e);
  endtask

  // Monitor: after each rising edge, compare outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (bus.kind !== e.kind || bus.size !== e.size ||
            bus.zero_ext !== e.zx || bus.illegal !== e.ill) begin
          n_bad++;
          $display("FAIL %s: got kind=%0d size=%b zext=%b ill=%b, want kind=%0d size=%b zext=%b ill=%b",
                   e.name, bus.kind, bus.size, bus.zero_ext, bus.illegal,
                   e.kind, e.size, e.zx, e.ill);
        end
      end
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    done  = 0;
    rst        = 1'b0;
    bus.funct3 = 3'b000;

    // Reset beats decode of a legal funct3.
    apply("reset_over_lb", 1'b0, 3'b000, lk_invalid, 2'b11, 1'b0, 1'b1);

    apply("lb",  1'b1, 3'b000, lk_lb,  2'b00, 1'b0, 1'b0);
    apply("lh",  1'b1, 3'b001, lk_lh,  2'b01, 1'b0, 1'b0);
    apply("lw",  1'b1, 3'b010, lk_lw,  2'b10, 1'b0, 1'b0);
    apply("lbu", 1'b1, 3'b100, lk_lbu, 2'b00, 1'b1, 1'b0);
    apply("lhu", 1'b1, 3'b101, lk_lhu, 2'b01, 1'b1, 1'b0);
    apply("f3_011", 1'b1, 3'b011, lk_invalid, 2'b11, 1'b0, 1'b1);
    apply("f3_110", 1'b1, 3'b110, lk_invalid, 2'b11, 1'b0, 1'b1);
    apply("f3_111", 1'b1, 3'b111, lk_invalid, 2'b11, 1'b0, 1'b1);

    // Latency: funct3 changed just after an edge must not reach the outputs early.
    apply("lat_lb", 1'b1, 3'b000, lk_lb, 2'b00, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    bus.funct3 = 3'b010;
    #1;
    n_vec++;
    if (bus.kind !== lk_lb || bus.size !== 2'b00) begin
      n_bad++;
      $display("FAIL lat_hold: got kind=%0d size=%b, want kind=%0d size=00",
               bus.kind, bus.size, lk_lb);
    end
    apply("lat_lw", 1'b1, 3'b010, lk_lw, 2'b10, 1'b0, 1'b0);

    // Mid-stream reset, then release with the same funct3.
    apply("rst_mid",     1'b0, 3'b010, lk_invalid, 2'b11, 1'b0, 1'b1);
    apply("rst_release", 1'b1, 3'b010, lk_lw,      2'b10, 1'b0, 1'b0);
    apply("lhu_after",   1'b1, 3'b101, lk_lhu,     2'b01, 1'b1, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #100000;
    if (!done) begin
      $display("FAIL timeout: got no completion, want completion");
      $fatal(1, "timeout");
    end
  end

endmodule

// File: doc/load_kind_decoder.md
Name: load_kind_decoder

Overview:
- Registered decoder for the RISC-V RV32I LOAD instruction's funct3 field.
- Produces the load kind (LB/LH/LW/LBU/LHU/invalid) plus derived access attributes.
- Sits in the decode stage and feeds the load/store unit and the illegal-instruction logic.
- Output is registered: one-cycle latency, synchronous active-low reset.

Parameters:
- none

Ports:
- clk  input  1  system clock; all state updates on its rising edge
- rst  input  1  reset, synchronous, active-low (asserted when 0, sampled on the rising clk edge)
- funct3  input  3  instruction bits [14:12] of a LOAD-opcode instruction
- kind  output  load_kind_t  decoded load kind (registered)
- size  output  2  access size, registered: 2'b00 byte, 2'b01 halfword, 2'b10 word, 2'b11 none/invalid
- zero_ext  output  1  registered; 1 = zero-extend the loaded value (LBU/LHU), 0 = sign-extend or not applicable
- illegal  output  1  registered; 1 when funct3 is not a legal load encoding

Behaviour:
- Reset: on a rising clk edge with rst==0:
  - kind=lk_invalid, size=2'b11, zero_ext=0, illegal=1.
  - Reset has priority over decode.
- Normal operation (rst==1): on each rising clk edge, register the decode of the current funct3:
  - 3'b000 -> lk_lb, size 00, zero_ext 0, illegal 0
  - 3'b001 -> lk_lh, size 01, zero_ext 0, illegal 0
  - 3'b010 -> lk_lw, size 10, zero_ext 0, illegal 0
  - 3'b100 -> lk_lbu, size 00, zero_ext 1, illegal 0
  - 3'b101 -> lk_lhu, size 01, zero_ext 1, illegal 0
  - 3'b011, 3'b110, 3'b111 -> lk_invalid, size 11, zero_ext 0, illegal 1
- Latency: outputs reflect the funct3 sampled at the previous rising edge. No combinational path from funct3 to any output.
- Any X/Z on funct3 decodes as lk_invalid, via the default branch.
- Outputs hold their value between edges. There is no enable; the block re-decodes every cycle.
- Reset released mid-stream: the first edge with rst==1 decodes the funct3 present at that edge.
- Consistency invariant: illegal==1 exactly when kind==lk_invalid. The implementation asserts this.

Decomposition:
- Shared package instr_type holds the enum load_kind_t, 3-bit logic with fixed encodings:
  - lk_lb=0, lk_lh=1, lk_lw=2, lk_lbu=3, lk_lhu=4, lk_invalid=7
- The same package holds the funct3 constants F3_LB=000, F3_LH=001, F3_LW=010, F3_LBU=100, F3_LHU=101, and the size constants.
- One combinational sub-module load_funct3_comb (funct3 -> kind, size, zero_ext, illegal) is natural.
- The top module only registers that sub-module's outputs with reset.

Test Plan:
- Hold rst=0 for one edge with funct3=000 -> kind=lk_invalid, size=11, illegal=1 (reset beats decode).
- rst=1; drive funct3=000, 001, 010 in turn, checking one cycle after each -> lk_lb/size 00, lk_lh/size 01, lk_lw/size 10; zero_ext=0 and illegal=0 in every case.
- funct3=100 then 101 -> lk_lbu/size 00/zero_ext 1, then lk_lhu/size 01/zero_ext 1; illegal=0.
- funct3=011, 110, 111 -> each gives lk_invalid, size 11, illegal 1, zero_ext 0.
- Latency: change funct3 000->010 just after an edge -> kind stays lk_lb until the next rising edge, then becomes lk_lw.
- Assert rst=0 mid-stream while funct3=010 -> the next edge gives lk_invalid. Release rst -> the following edge gives lk_lw.
